// File: rtl/hns_sched_pkg.sv
// hns_sched_pkg: shared FSM encoding, requester ids and defaults for hns_job_scheduler.
package hns_sched_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    LOAD    = 3'd2,
    START   = 3'd3,
    RUN     = 3'd4,
    CAPTURE = 3'd5,
    REPORT  = 3'd6,
    HOLD    = 3'd7
  } sched_state_e;
  localparam logic REQ_UART = 1'b0;
  localparam logic REQ_SPI  = 1'b1;
  localparam int unsigned CHUNK_DEF        = 256;
  localparam int unsigned BUSY_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/hns_rr_arbiter.sv
// hns_rr_arbiter: 2-way round-robin grant; pointer moves past the requester granted on adv_i.
module hns_rr_arbiter
  import hns_sched_pkg::*;
(
  input  logic       clk_100m,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       gnt_id_o,
  output logic       any_o
);
  logic ptr_q;
  assign any_o    = |req_i;
  assign gnt_id_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
  always_ff @(posedge clk_100m or negedge reset_n)
    if (!reset_n) ptr_q <= REQ_UART;
    else if (adv_i && any_o) ptr_q <= (gnt_id_o == REQ_SPI) ? REQ_UART : REQ_SPI;
endmodule

// File: rtl/hns_job_scheduler.sv
// hns_job_scheduler: arbitrates UART/SPI mining jobs and feeds them to the ASIC in CHUNK-sized slices.
// Optional busy-handshake watchdog enabled by defining HNS_SCHED_TIMEOUT_EN.
module hns_job_scheduler
  import hns_sched_pkg::*;
#(
  parameter int unsigned CHUNK        = CHUNK_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic         clk_100m,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [511:0] req_header,
  input  logic [63:0]  req_start,
  input  logic [63:0]  req_range,
  output logic [255:0] job_header,
  output logic [31:0]  start_nonce,
  output logic [31:0]  nonce_range,
  output logic         mining_enable,
  input  logic         pipeline_busy,
  input  logic         thermal_throttle,
  input  logic         hns_valid,
  input  logic [31:0]  hns_phi,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [31:0]  res_nonce,
  output logic [31:0]  res_phi,
  output logic [2:0]   sched_state,
  output logic         err_timeout
);
  localparam logic [31:0] CHUNK_W = 32'(CHUNK);
  sched_state_e state_q;
  logic [255:0] hdr_q;
  logic [31:0]  nonce_q, rem_q, res_nonce_q, res_phi_q, slice;
  logic         id_q, res_id_q, arb_id, arb_any;
  hns_rr_arbiter u_arb (
    .clk_100m (clk_100m),
    .reset_n  (reset_n),
    .req_i    (req_valid),
    .adv_i    (state_q == ARB),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );
  assign slice         = (rem_q < CHUNK_W) ? rem_q : CHUNK_W;
  assign req_ready     = (state_q == ARB && arb_any) ? (2'b01 << arb_id) : 2'b00;
  assign job_header    = hdr_q;
  assign start_nonce   = nonce_q;
  assign nonce_range   = slice;
  assign mining_enable = (state_q == START) || (state_q == RUN);
  assign res_valid     = state_q == REPORT;
  assign res_id        = res_id_q;
  assign res_nonce     = res_nonce_q;
  assign res_phi       = res_phi_q;
  assign sched_state   = state_q;
`ifdef HNS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  wire           tmo_hit = tmo_q == TW'(BUSY_TIMEOUT - 1);
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk_100m or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      rem_q       <= '0;
      id_q        <= REQ_UART;
      res_id_q    <= REQ_UART;
      res_nonce_q <= '0;
      res_phi_q   <= '0;
`ifdef HNS_SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef HNS_SCHED_TIMEOUT_EN
      tmo_q <= '0;
`endif
      case (state_q)
        IDLE: if (|req_valid) state_q <= ARB;
        ARB: begin
          hdr_q   <= req_header[{arb_id, 8'd0} +: 256];
          nonce_q <= req_start[{arb_id, 5'd0} +: 32];
          rem_q   <= req_range[{arb_id, 5'd0} +: 32];
          id_q    <= arb_id;
          state_q <= (arb_any && req_range[{arb_id, 5'd0} +: 32] != '0) ? LOAD : IDLE;
        end
        LOAD: state_q <= thermal_throttle ? HOLD : START;
        HOLD: if (!thermal_throttle) state_q <= LOAD;
        START:
          if (pipeline_busy) state_q <= RUN;
`ifdef HNS_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else tmo_q <= tmo_q + 1'b1;
`endif
        RUN:
          if (!pipeline_busy) state_q <= CAPTURE;
`ifdef HNS_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else tmo_q <= tmo_q + 1'b1;
`endif
        CAPTURE:
          if (hns_valid) begin
            res_phi_q   <= hns_phi;
            res_nonce_q <= nonce_q;
            res_id_q    <= id_q;
            state_q     <= REPORT;
          end
        REPORT:
          if (res_ready) begin
            nonce_q <= nonce_q + slice;
            rem_q   <= rem_q - slice;
            state_q <= (rem_q == slice) ? IDLE : LOAD;
          end
      endcase
    end
endmodule

// File: tb/tb_hns_job_scheduler.sv
// tb_hns_job_scheduler: directed stimulus with queue scoreboards for grants, slices and results.
module tb_hns_job_scheduler;
  typedef struct packed {logic id; logic [31:0] nonce; logic [31:0] phi;} res_t;
  typedef struct packed {logic [31:0] st; logic [31:0] rng; logic [255:0] hdr;} slc_t;
  localparam logic [255:0] H0 = {8{32'h1111_0000}};
  localparam logic [255:0] H1 = {8{32'h2222_0001}};
  logic clk_100m = 0, reset_n = 0;
  logic [1:0] req_valid = 0, req_ready;
  logic [511:0] req_header = {H1, H0};
  logic [63:0] req_start = 0, req_range = 0;
  logic [255:0] job_header;
  logic [31:0] start_nonce, nonce_range, hns_phi = 0, res_nonce, res_phi;
  logic mining_enable, pipeline_busy = 0, thermal_throttle = 0, hns_valid = 0;
  logic res_valid, res_ready = 1, res_id, err_timeout;
  logic [2:0] sched_state;
  logic asic_auto = 1;
  int n_cmp = 0, n_err = 0;
  res_t res_q[$];
  slc_t slc_q[$];
  logic [1:0] gnt_q[$];

  hns_job_scheduler dut (
    .clk_100m(clk_100m), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_header(req_header), .req_start(req_start), .req_range(req_range),
    .job_header(job_header), .start_nonce(start_nonce), .nonce_range(nonce_range),
    .mining_enable(mining_enable), .pipeline_busy(pipeline_busy), .thermal_throttle(thermal_throttle),
    .hns_valid(hns_valid), .hns_phi(hns_phi), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_nonce(res_nonce), .res_phi(res_phi), .sched_state(sched_state),
    .err_timeout(err_timeout)
  );

  always #5 clk_100m = ~clk_100m;

  function automatic logic [31:0] phi_of(input logic [31:0] s);
    return s ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #2;
  endtask

  task automatic push_sr(input logic id, input logic [31:0] st, input logic [31:0] rng);
    slc_q.push_back('{st: st, rng: rng, hdr: id ? H1 : H0});
    res_q.push_back('{id: id, nonce: st, phi: phi_of(st)});
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    for (int k = 0; k < lim && sched_state != s; k++) tick();
    chk("wait_state", sched_state, s);
  endtask

  task automatic send(input int i, input logic [31:0] st, input logic [31:0] rng);
    req_start[32*i +: 32] = st;
    req_range[32*i +: 32] = rng;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 200 && !req_ready[i]; k++) tick();
    chk("send_ready", req_ready[i], 1'b1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int k = 0; k < lim && !(sched_state == 0 && res_q.size() == 0 && slc_q.size() == 0); k++) tick();
    chk("drain_res", res_q.size(), 0);
    chk("drain_slc", slc_q.size(), 0);
    chk("drain_state", sched_state, 0);
  endtask

  // ASIC model: raises busy in START, drops it after 3 RUN cycles, returns phi while in CAPTURE
  initial begin : asic
    int run_cnt;
    run_cnt = 0;
    forever begin
      tick();
      if (asic_auto) begin
        if (sched_state == 3) begin pipeline_busy = 1; run_cnt = 0; end
        else if (sched_state == 4) begin run_cnt++; pipeline_busy = run_cnt < 3; end
        else pipeline_busy = 0;
        hns_valid = sched_state == 5;
        hns_phi = phi_of(start_nonce);
      end
    end
  end

  initial begin : mon_res
    res_t e;
    forever begin
      @(negedge clk_100m);
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL res_unexpected: got nonce %0h expected no result", res_nonce);
        end else begin
          e = res_q.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_nonce", res_nonce, e.nonce);
          chk("res_phi", res_phi, e.phi);
        end
      end
    end
  end

  initial begin : mon_slc
    slc_t e;
    logic [2:0] ps;
    ps = 0;
    forever begin
      @(negedge clk_100m);
      if (sched_state == 3 && ps != 3) begin
        if (slc_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL slc_unexpected: got start %0h expected no slice", start_nonce);
        end else begin
          e = slc_q.pop_front();
          chk("start_nonce", start_nonce, e.st);
          chk("nonce_range", nonce_range, e.rng);
          chk("job_header", job_header, e.hdr);
          chk("mining_en", mining_enable, 1'b1);
        end
      end
      ps = sched_state;
    end
  end

  initial begin : mon_gnt
    logic [1:0] prev;
    prev = 0;
    forever begin
      @(negedge clk_100m);
      if (req_ready != 0) begin
        chk("rdy_pulse", prev, 2'b00);
        if (gnt_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL gnt_unexpected: got %0b expected none", req_ready);
        end else chk("grant", req_ready, gnt_q.pop_front());
      end
      prev = req_ready;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g, cnt;
    #1;
    chk("rst_state", sched_state, 0);
    chk("rst_mining", mining_enable, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_nonce", start_nonce, 0);
    repeat (2) tick();
    reset_n = 1;
    tick();
    // single job, one slice
    gnt_q.push_back(2'b01); push_sr(0, 32'h10, 5);
    send(0, 32'h10, 5);
    drain(200);
    // multi-slice with nonce wrap
    gnt_q.push_back(2'b10); push_sr(1, 32'hFFFF_FF00, 256); push_sr(1, 32'h0, 256);
    send(1, 32'hFFFF_FF00, 512);
    drain(400);
    // fairness with both requesters continuously valid
    for (int j = 0; j < 4; j++) begin
      gnt_q.push_back(j[0] ? 2'b10 : 2'b01);
      push_sr(j[0], j[0] ? 32'h200 : 32'h100, 1);
    end
    req_start = {32'h200, 32'h100}; req_range = {32'd1, 32'd1}; req_valid = 2'b11;
    g = 0;
    for (int k = 0; k < 400 && g < 4; k++) begin tick(); if (req_ready != 0) g++; end
    chk("fair_grants", g, 4);
    tick();
    req_valid = 0;
    drain(400);
    // zero-range job: accepted, no slice, no result
    gnt_q.push_back(2'b10);
    send(1, 32'h5, 0);
    chk("zero_idle", sched_state, 0);
    repeat (3) tick();
    chk("zero_idle2", sched_state, 0);
    chk("zero_mining", mining_enable, 0);
    // thermal hold at LOAD
    thermal_throttle = 1;
    gnt_q.push_back(2'b01); push_sr(0, 32'h40, 3);
    send(0, 32'h40, 3);
    wait_state(7, 10);
    for (int n = 0; n < 20; n++) begin
      chk("hold_state", sched_state, 7);
      chk("hold_mining", mining_enable, 0);
      if (n < 19) tick();
    end
    thermal_throttle = 0;
    tick();
    chk("hold_load", sched_state, 2);
    tick();
    chk("hold_start", sched_state, 3);
    drain(200);
    // result back-pressure
    res_ready = 0;
    gnt_q.push_back(2'b10); push_sr(1, 32'h1234, 7);
    send(1, 32'h1234, 7);
    wait_state(6, 100);
    for (int n = 0; n < 50; n++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_id", res_id, 1);
      chk("bp_nonce", res_nonce, 32'h1234);
      chk("bp_phi", res_phi, phi_of(32'h1234));
      tick();
    end
    res_ready = 1;
    drain(200);
    // asynchronous reset during RUN
    gnt_q.push_back(2'b01);
    slc_q.push_back('{st: 32'h500, rng: 256, hdr: H0});
    send(0, 32'h500, 300);
    wait_state(4, 100);
    reset_n = 0;
    #1;
    chk("arst_state", sched_state, 0);
    chk("arst_mining", mining_enable, 0);
    chk("arst_header", job_header, 0);
    chk("arst_start", start_nonce, 0);
    chk("arst_range", nonce_range, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_nonce", res_nonce, 0);
    chk("arst_res_phi", res_phi, 0);
    chk("arst_res_id", res_id, 0);
    chk("arst_ready", req_ready, 0);
    repeat (2) tick();
    reset_n = 1;
    repeat (5) tick();
    drain(10);
`ifdef HNS_SCHED_TIMEOUT_EN
    // pipeline_busy never rises: watchdog abandons the job
    asic_auto = 0; pipeline_busy = 0; hns_valid = 0;
    gnt_q.push_back(2'b01);
    slc_q.push_back('{st: 32'h700, rng: 4, hdr: H0});
    send(0, 32'h700, 4);
    wait_state(3, 10);
    cnt = 0;
    while (sched_state == 3 && cnt < 2000) begin cnt++; tick(); end
    chk("tmo_cycles", cnt, 1024);
    chk("tmo_state", sched_state, 0);
    chk("tmo_err", err_timeout, 1);
    drain(10);
`else
    chk("no_tmo_err", err_timeout, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hns_job_scheduler.md
HNS_JOB_SCHEDULER -- requirements
Module: hns_job_scheduler

Interface
REQ-001 Parameter CHUNK, default 256, nonces issued to the ASIC per slice (power of two, 1..2^16).
REQ-002 Parameter BUSY_TIMEOUT, default 1024, cycles allowed for pipeline_busy to rise, and separately to fall, per slice.
REQ-003 clk_100m  in  1  sole clock; reset is asynchronous and active-low.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  2 / req_ready  out  2: per-requester job handshake (0 = UART host, 1 = SPI host).
REQ-006 req_header  in  512  job headers; requester i at bits [256*i+255 : 256*i].
REQ-007 req_start  in  64 / req_range  in  64  start nonce and nonce count; requester i in 32-bit lane i.
REQ-008 job_header  out  256 / start_nonce  out  32 / nonce_range  out  32 / mining_enable  out  1  drive to the ASIC.
REQ-009 pipeline_busy  in  1 / thermal_throttle  in  1 / hns_valid  in  1 / hns_phi  in  32: from the ASIC.
REQ-010 res_valid  out  1 / res_ready  in  1 / res_id  out  1 / res_nonce  out  32 / res_phi  out  32: per-slice result.
REQ-011 sched_state  out  3  current FSM state code / err_timeout  out  1  sticky timeout flag.

Function
REQ-012 FSM states and codes: IDLE=0, ARB=1, LOAD=2, START=3, RUN=4, CAPTURE=5, REPORT=6, HOLD=7.
REQ-013 IDLE to ARB when any req_valid=1.
- ARB grants round-robin; the pointer moves past the last granted requester.
- Only one requester pending: that requester is granted regardless of the pointer.
REQ-014 req_ready[i] pulses for exactly one cycle in ARB when i is granted.
- The job is latched on that cycle: header, start, remaining = range, id = i.
REQ-015 Job with range 0: ARB returns to IDLE after accept; no slice and no result are produced.
REQ-016 LOAD drives the slice.
- job_header = latched header; start_nonce = current nonce; nonce_range = min(CHUNK, remaining).
- Then to START, or to HOLD if thermal_throttle=1.
REQ-017 HOLD keeps mining_enable=0 and returns to LOAD on the first cycle thermal_throttle=0.
REQ-018 mining_enable=1 throughout START and RUN; 0 in every other state.
REQ-019 START to RUN on pipeline_busy=1.
REQ-020 RUN to CAPTURE on pipeline_busy=0.
REQ-021 CAPTURE waits for hns_valid=1, then latches res_phi = hns_phi and res_nonce = slice start nonce, and goes to REPORT.
REQ-022 REPORT holds res_valid=1 with stable res_* until res_ready=1.
- On that cycle: current nonce += slice size (modulo 2^32, wrap permitted); remaining -= slice size.
- Next state is LOAD if remaining > 0, else IDLE.
REQ-023 req_valid deasserting mid-job has no effect; a latched job always runs to completion.
REQ-024 thermal_throttle asserted during START, RUN, CAPTURE or REPORT is ignored until the next LOAD.

Reset
REQ-025 reset_n=0 forces, immediately and asynchronously:
- state IDLE; RR pointer 0; all res_* and ASIC drive outputs 0; err_timeout 0.
REQ-026 Reset asserted mid-job discards the job without emitting a result; mining_enable drops in the same cycle.

Configuration
REQ-027 Macro HNS_SCHED_TIMEOUT_EN: when defined, START or RUN lasting BUSY_TIMEOUT cycles:
- sets err_timeout (cleared only by reset);
- abandons the job and returns to IDLE with no result.
REQ-028 Without HNS_SCHED_TIMEOUT_EN: START and RUN wait indefinitely, no timeout counter exists, and err_timeout is tied to 0.

Structure
REQ-029 Package hns_sched_pkg holds the FSM state enum, the requester-id constants, and the CHUNK and BUSY_TIMEOUT defaults.
REQ-030 Sub-module hns_rr_arbiter (2-way round-robin, grant plus pointer update); all other logic stays in hns_job_scheduler.

Verification
REQ-031 Single job, one slice:
- Stimulus: req0 range=5, start=0x10, CHUNK=256.
- Response: nonce_range=5, start_nonce=0x10, one result with res_id=0 and res_nonce=0x10.
REQ-032 Multi-slice with wrap:
- Stimulus: req1 start=0xFFFFFF00, range=512.
- Response: two slices, start 0xFFFFFF00 then 0x00000000, each nonce_range=256.
REQ-033 Fairness:
- Stimulus: both requesters valid continuously, one-slice jobs.
- Response: grant order 0,1,0,1; each req_ready is a one-cycle pulse.
REQ-034 Thermal hold:
- Stimulus: thermal_throttle=1 at LOAD for 20 cycles.
- Response: sched_state=7, mining_enable=0 for those 20 cycles, then START.
REQ-035 Timeout (macro defined):
- Stimulus: pipeline_busy held 0 for 1024 cycles.
- Response: err_timeout=1, state IDLE, no res_valid.
REQ-036 Back-pressure and reset:
- Stimulus: res_ready=0 for 50 cycles.
- Response: res_* stable throughout.
- Stimulus: reset_n=0 during RUN.
- Response: all outputs 0 immediately.
